// File: rtl/mem_rw_arbiter_if.sv
// Bundle of requestor-side and memory-side signals for mem_rw_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_rw_arbiter_if #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = DATA_WIDTH/8
);
  logic [NUM_PORTS-1:0]             req_read;
  logic [NUM_PORTS-1:0]             req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_PORTS*WMASK_WIDTH-1:0] req_wmask;
  logic [NUM_PORTS-1:0]             req_resp;
  logic [DATA_WIDTH-1:0]            req_rdata;
  logic                             mem_read;
  logic                             mem_write;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]            mem_wdata;
  logic [WMASK_WIDTH-1:0]           mem_wmask;
  logic                             mem_resp;
  logic [DATA_WIDTH-1:0]            mem_rdata;

  modport master (
    input  req_read, req_write, req_addr, req_wdata, req_wmask, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata, req_wmask, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin N-port read/write arbiter in front of a single line-wide memory
// server; one transaction in flight, response returned to the granted port.
module mem_rw_arbiter #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = DATA_WIDTH/8
) (
  input logic              clk,
  input logic              rst,
  mem_rw_arbiter_if.master bus
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_q, rr_d, grant_q, grant_d, sel;
  logic                   found;
  logic                   op_write_q, op_write_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [NUM_PORTS-1:0]   resp_q, resp_d;
  logic [NUM_PORTS-1:0]   pending;
  int unsigned            idx;

  assign pending = bus.req_read | bus.req_write;

  // First pending port at or after rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = i + 32'(rr_q);
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && pending[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    resp_d     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = sel;
          op_write_d = bus.req_write[sel];
          addr_d     = bus.req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = bus.req_wdata[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
          wmask_d    = bus.req_wmask[32'(sel)*WMASK_WIDTH +: WMASK_WIDTH];
          rr_d       = (sel == PW'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
          rd_d       = !bus.req_write[sel];
          wr_d       = bus.req_write[sel];
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          if (!op_write_q) rdata_d = bus.mem_rdata;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          resp_d[grant_q] = 1'b1;
          state_d         = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      resp_q     <= resp_d;
    end
  end

  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.req_resp  = resp_q;
  assign bus.req_rdata = rdata_q;
endmodule
